wm8731_init_seq: RTL and testbench
==================================

WM8731_INIT_SEQ -- requirements
Module: wm8731_init_seq

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: idle clocks inserted after each completed I2C write.
REQ-002 SHALL have parameter LAUNCH_TIMEOUT, default 8: max clocks from wr_i2c pulse to i2c_idle falling.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to (re)run the codec init table.
REQ-006 SHALL have port usr_req  input  1  level request for one user register write, held until usr_ack.
REQ-007 SHALL have port usr_data  input  24  user write word {dev addr 0x34, 7-bit reg, 9-bit data}.
REQ-008 SHALL have port usr_ack  output  1  one-clock pulse when the user write is launched.
REQ-009 SHALL have port i2c_idle  input  1  idle flag from I2C master; high = ready.
REQ-010 SHALL have port din  output  24  word to the I2C master.
REQ-011 SHALL have port wr_i2c  output  1  one-clock write strobe to the I2C master.
REQ-012 SHALL have ports busy, init_done, err (output, 1 each) and step (output, 4): FSM not IDLE / table completed / launch timeout / current table index.

Function
REQ-013 SHALL implement states IDLE, LOAD, LAUNCH, XFER, GAP.
REQ-014 SHALL hold a fixed 11-entry table, index 0..10: 341E00 (R15 reset), 340C00, 340017, 340217, 340479, 340679, 340812, 340A00, 340E02, 341000, 341201 (hex).
REQ-015 IDLE: if start or pending-start, SHALL set step=0, clear init_done and err, clear pending-start, load table[0] into din, go LOAD.
REQ-016 IDLE: else if usr_req and init_done, SHALL load usr_data into din, pulse usr_ack that same clock, mark source=user, go LOAD.
REQ-017 IDLE: usr_req while init_done=0 SHALL be ignored (no usr_ack); start has priority over usr_req in the same clock.
REQ-018 LOAD: SHALL wait for i2c_idle=1, then assert wr_i2c for exactly one clock and go LAUNCH.
REQ-019 LAUNCH: i2c_idle=0 SHALL go XFER; if LAUNCH_TIMEOUT clocks elapse first, SHALL set err=1, clear init_done, abort sequence, go IDLE.
REQ-020 XFER: SHALL wait for i2c_idle=1, then go GAP.
REQ-021 GAP: after GAP_CYCLES clocks: init source with step<10 -> step+1, din=table[step+1], LOAD; step==10 -> init_done=1, IDLE; user source -> IDLE.
REQ-022 din SHALL remain stable from LOAD entry until GAP exit; wr_i2c SHALL never be high outside LOAD->LAUNCH transition.
REQ-023 start asserted while busy=1 SHALL set pending-start, serviced at next IDLE; multiple starts collapse to one.
REQ-024 busy SHALL be 1 in every state except IDLE; step SHALL hold its last value in IDLE.

Reset
REQ-025 reset SHALL force IDLE, din=0, wr_i2c=0, usr_ack=0, busy=0, init_done=0, err=0, step=0, counters 0, pending-start=0 (except REQ-027).
REQ-026 reset asserted mid-transfer SHALL abort immediately; no further wr_i2c until a new sequence starts.

Configuration
REQ-027 With WM8731_INIT_AUTOSTART_EN defined, reset SHALL set pending-start=1 so the table runs on the first clock after reset deasserts; undefined, the table runs only on start.

Verification
REQ-028 reset 5 clk, start 1 clk, I2C model idle 4 clk after each strobe -> 11 wr_i2c pulses, din 341E00 ... 341201 in order, init_done=1, busy=0.
REQ-029 i2c_idle stuck high after strobe on step 3 -> err=1 at 8 clk after strobe, init_done=0, step=3, no further strobes.
REQ-030 usr_req with usr_data=340479 after init_done -> usr_ack one clock, one wr_i2c with din=340479, init_done stays 1; usr_req before init_done -> no usr_ack.
REQ-031 start pulsed twice during a user write -> exactly one full 11-write sequence follows.
REQ-032 reset mid-XFER at step 5 -> all outputs 0 next clock; with WM8731_INIT_AUTOSTART_EN, sequence restarts at step 0 unprompted.

Source files
------------

// File: rtl/wm8731_init_seq.sv
// wm8731_init_seq -- walks the WM8731 codec register init table through an
// external I2C write master, then accepts single user register writes.
// Each word goes through LOAD -> LAUNCH -> XFER -> GAP.
// Optional feature: define WM8731_INIT_AUTOSTART_EN to have the table run
// right after reset is released, without waiting for a start pulse.
module wm8731_init_seq #(
    parameter int GAP_CYCLES     = 16,
    parameter int LAUNCH_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        usr_req,
    input  logic [23:0] usr_data,
    output logic        usr_ack,
    input  logic        i2c_idle,
    output logic [23:0] din,
    output logic        wr_i2c,
    output logic        busy,
    output logic        init_done,
    output logic        err,
    output logic [3:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_XFER,
        S_GAP
    } state_e;

    // One counter serves both the launch timeout and the inter-write gap.
    localparam int CNT_MAX = (GAP_CYCLES > LAUNCH_TIMEOUT) ? GAP_CYCLES : LAUNCH_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [3:0]       LAST_STEP   = 4'd10;

`ifdef WM8731_INIT_AUTOSTART_EN
    localparam logic PEND_RST = 1'b1;
`else
    localparam logic PEND_RST = 1'b0;
`endif

    // Codec init table; entry 0 resets the codec (R15) before anything else.
    function automatic logic [23:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = 24'h341E00;
            4'd1:    table_word = 24'h340C00;
            4'd2:    table_word = 24'h340017;
            4'd3:    table_word = 24'h340217;
            4'd4:    table_word = 24'h340479;
            4'd5:    table_word = 24'h340679;
            4'd6:    table_word = 24'h340812;
            4'd7:    table_word = 24'h340A00;
            4'd8:    table_word = 24'h340E02;
            4'd9:    table_word = 24'h341000;
            4'd10:   table_word = 24'h341201;
            default: table_word = 24'h000000;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [23:0]      din_q, din_d;
    logic             wr_i2c_q, wr_i2c_d;
    logic             usr_ack_q, usr_ack_d;
    logic             busy_q, busy_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             user_q, user_d;   // current word came from the user port

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        din_d       = din_q;
        wr_i2c_d    = 1'b0;
        usr_ack_d   = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        user_d      = user_q;

        // A start that arrives mid-word is remembered and run at the next IDLE.
        if (start && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start || pend_q) begin
                    step_d      = 4'd0;
                    init_done_d = 1'b0;
                    err_d       = 1'b0;
                    pend_d      = 1'b0;
                    din_d       = table_word(4'd0);
                    user_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_LOAD;
                end else if (usr_req && init_done_q) begin
                    din_d     = usr_data;
                    usr_ack_d = 1'b1;
                    user_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_LOAD;
                end
            end

            S_LOAD: begin
                if (i2c_idle) begin
                    wr_i2c_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                if (!i2c_idle) begin
                    state_d = S_XFER;
                end else if (cnt_q == LAUNCH_LAST) begin
                    // Master never acknowledged the strobe: give up on the sequence.
                    err_d       = 1'b1;
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_XFER: begin
                if (i2c_idle) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (user_q) begin
                        state_d = S_IDLE;
                    end else if (step_q == LAST_STEP) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        step_d  = step_q + 4'd1;
                        din_d   = table_word(step_q + 4'd1);
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            din_q       <= '0;
            wr_i2c_q    <= 1'b0;
            usr_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            step_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= PEND_RST;
            user_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            din_q       <= din_d;
            wr_i2c_q    <= wr_i2c_d;
            usr_ack_q   <= usr_ack_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            user_q      <= user_d;
        end
    end

    assign din       = din_q;
    assign wr_i2c    = wr_i2c_q;
    assign usr_ack   = usr_ack_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign err       = err_q;
    assign step      = step_q;

endmodule

// File: tb/tb_wm8731_init_seq.sv
// tb_wm8731_init_seq -- scoreboard bench for wm8731_init_seq.
// Stimulus pushes the words it expects to see strobed (and acked) into
// queues; a monitor pops them whenever the DUT strobes or acks.
// A small I2C master model answers each strobe by dropping i2c_idle.
module tb_wm8731_init_seq;

    localparam logic [23:0] INIT_TABLE [11] = '{
        24'h341E00, 24'h340C00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
        24'h340812, 24'h340A00, 24'h340E02, 24'h341000, 24'h341201
    };

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        usr_req;
    logic [23:0] usr_data;
    logic        usr_ack;
    logic        i2c_idle;
    logic [23:0] din;
    logic        wr_i2c;
    logic        busy;
    logic        init_done;
    logic        err;
    logic [3:0]  step;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    logic [23:0] exp_q [$];     // words expected on din at each wr_i2c
    logic [23:0] ack_q [$];     // words expected on din at each usr_ack
    logic [23:0] mon_e;

    bit          fixed_timing  = 1'b1;
    int          stuck_at      = -1;
    int          model_strobes = 0;
    int          dly;
    int          len;

    wm8731_init_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .usr_req   (usr_req),
        .usr_data  (usr_data),
        .usr_ack   (usr_ack),
        .i2c_idle  (i2c_idle),
        .din       (din),
        .wr_i2c    (wr_i2c),
        .busy      (busy),
        .init_done (init_done),
        .err       (err),
        .step      (step)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every strobe and every ack must match the queue head.
    initial forever begin
        @(negedge clk);
        if (wr_i2c === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: din 0x%0h, no write expected", din);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_din", 32'(din), 32'(mon_e));
            end
        end
        if (usr_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_usr_ack: din 0x%0h, no ack expected", din);
            end else begin
                mon_e = ack_q.pop_front();
                check("usr_ack_din", 32'(din), 32'(mon_e));
            end
        end
    end

    // I2C master model: goes busy after a strobe, then idle again.
    initial begin
        i2c_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (wr_i2c === 1'b1) begin
                if (model_strobes == stuck_at) begin
                    model_strobes++;
                end else begin
                    model_strobes++;
                    dly = fixed_timing ? 0 : int'($urandom_range(3, 0));
                    len = fixed_timing ? 4 : int'($urandom_range(6, 1));
                    repeat (dly) @(negedge clk);
                    i2c_idle = 1'b0;
                    repeat (len) @(negedge clk);
                    i2c_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_table(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(INIT_TABLE[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_strobes(input string name, input int n, input int budget, output int last_cyc);
        int seen = 0;
        int k    = 0;
        last_cyc = cyc;
        while (seen < n && k < budget) begin
            @(negedge clk);
            k++;
            if (wr_i2c === 1'b1) begin
                seen++;
                last_cyc = cyc;
            end
        end
        check({name, "_strobes"}, 32'(seen), 32'(n));
    endtask

    task automatic user_write(input logic [23:0] d);
        int k = 0;
        exp_q.push_back(d);
        ack_q.push_back(d);
        usr_data = d;
        usr_req  = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (usr_ack !== 1'b1 && k < 20);
        check("usr_ack_seen", 32'(usr_ack), 32'd1);
        usr_req = 1'b0;
    endtask

    function automatic logic [23:0] rand_word();
        logic [6:0] r;
        logic [8:0] v;
        r = 7'($urandom_range(127, 0));
        v = 9'($urandom_range(511, 0));
        return {8'h34, r, v};
    endfunction

    initial begin
        int c0;
        int n;
        int acks;
        reset    = 1'b1;
        start    = 1'b0;
        usr_req  = 1'b0;
        usr_data = '0;

        // Reset state
        tick(5);
        check("reset_din",       32'(din),       32'd0);
        check("reset_wr_i2c",    32'(wr_i2c),    32'd0);
        check("reset_usr_ack",   32'(usr_ack),   32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_init_done", 32'(init_done), 32'd0);
        check("reset_err",       32'(err),       32'd0);
        check("reset_step",      32'(step),      32'd0);

        // Full init table, fixed 4-clock I2C busy time
`ifdef WM8731_INIT_AUTOSTART_EN
        push_table(11);
        reset = 1'b0;
`else
        reset = 1'b0;
        tick(10);
        check("no_autostart_busy", 32'(busy), 32'd0);
        push_table(11);
        pulse_start();
`endif
        wait_drain("init_seq", 2000);
        check("init_done_set",  32'(init_done), 32'd1);
        check("init_step_last", 32'(step),      32'd10);
        check("init_err_clear", 32'(err),       32'd0);

        // User writes with randomized I2C timing
        fixed_timing = 1'b0;
        for (int i = 0; i < 6; i++) begin
            user_write((i == 0) ? 24'h340479 : rand_word());
            wait_drain("usr_write", 300);
            check("usr_keeps_init_done", 32'(init_done), 32'd1);
            check("usr_keeps_step",      32'(step),      32'd10);
        end

        // start and usr_req in the same clock: start wins, no ack
        push_table(11);
        usr_data = rand_word();
        usr_req  = 1'b1;
        start    = 1'b1;
        tick(1);
        usr_req  = 1'b0;
        start    = 1'b0;
        wait_drain("prio", 3000);
        check("prio_init_done", 32'(init_done), 32'd1);

        // Two starts during a user write collapse into one sequence
        user_write(rand_word());
        push_table(11);
        tick(3);
        pulse_start();
        tick(5);
        pulse_start();
        wait_drain("double_start", 3000);
        tick(40);
        check("double_start_done", 32'(init_done), 32'd1);
        check("double_start_idle", 32'(busy),      32'd0);

        // Master ignores the strobe on step 3: launch timeout
        stuck_at = model_strobes + 3;
        push_table(4);
        pulse_start();
        wait_strobes("timeout", 4, 2000, c0);
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err",       32'(err),       32'd1);
        check("timeout_latency",   32'(cyc - c0),  32'd8);
        check("timeout_init_done", 32'(init_done), 32'd0);
        check("timeout_step",      32'(step),      32'd3);
        check("timeout_busy",      32'(busy),      32'd0);
        tick(30);
        check("timeout_queue", 32'(exp_q.size()), 32'd0);
        stuck_at = -1;

        // usr_req without init_done is ignored
        usr_data = 24'h340479;
        usr_req  = 1'b1;
        acks     = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (usr_ack === 1'b1) acks++;
        end
        usr_req = 1'b0;
        check("ignored_usr_ack",  32'(acks), 32'd0);
        check("ignored_usr_busy", 32'(busy), 32'd0);

        // Reset in the middle of the step-5 transfer
        fixed_timing = 1'b1;
        push_table(6);
        pulse_start();
        wait_strobes("rst_xfer", 6, 2000, c0);
        tick(1);
        check("pre_reset_step", 32'(step), 32'd5);
        reset = 1'b1;
        tick(1);
        check("mid_reset_din",       32'(din),       32'd0);
        check("mid_reset_wr_i2c",    32'(wr_i2c),    32'd0);
        check("mid_reset_usr_ack",   32'(usr_ack),   32'd0);
        check("mid_reset_busy",      32'(busy),      32'd0);
        check("mid_reset_init_done", 32'(init_done), 32'd0);
        check("mid_reset_err",       32'(err),       32'd0);
        check("mid_reset_step",      32'(step),      32'd0);
`ifdef WM8731_INIT_AUTOSTART_EN
        push_table(11);
        reset = 1'b0;
        wait_drain("autorestart", 3000);
        check("autorestart_done", 32'(init_done), 32'd1);
`else
        reset = 1'b0;
        tick(40);
        check("post_reset_busy",  32'(busy),      32'd0);
        check("post_reset_step",  32'(step),      32'd0);
        check("post_reset_done",  32'(init_done), 32'd0);
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);
`endif
        check("ack_queue_empty", 32'(ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
